debug_scan_master: RTL and testbench
====================================

Name: debug_scan_master

Overview:
- Host-side initiator for the CPU debug slave's virtual-JTAG scan interface. It drives the slave's tck, tdi, ir_in and virtual-state strobes, and captures its tdo and ir_out.
- Used by on-chip test logic and simulation benches to issue debug-slave commands without a physical JTAG chain.
- One command is an IR value plus a DR payload. The block performs one full UIR → CDR → SDR×N → UDR → RTI scan, then returns the captured DR contents and IR_out.

Parameters:
- DR_WIDTH, 38, scan data-register length in bits.
- IR_WIDTH, 2, instruction width.
- TCK_DIV, 2, clk cycles per tck half-period (≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only
- cmd_ir  in  IR_WIDTH  instruction to load
- cmd_dr  in  DR_WIDTH  data to shift in, LSB first
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_dr  out  DR_WIDTH  data shifted out of the slave
- rsp_ir_out  out  IR_WIDTH  slave ir_out sampled during UIR
- vs_tck  out  1  generated scan clock
- vs_tdi  out  1  serial data to slave
- vs_tdo  in  1  serial data from slave
- vs_ir_in  out  IR_WIDTH  instruction presented to slave
- vs_ir_out  in  IR_WIDTH  slave status
- vs_uir, vs_cdr, vs_sdr, vs_udr, vs_rti  out  1 each  virtual-state strobes

Behaviour:
- Reset, asynchronous: state IDLE; cmd_ready=1, vs_rti=1; all other outputs 0, including rsp_dr, rsp_ir_out and vs_ir_in. Reset mid-scan aborts immediately; no response is produced.
- States: IDLE, UIR, CDR, SHIFT, UDR, RTI, RESP.
- Each non-IDLE/RESP state occupies exactly one tck period of 2·TCK_DIV clk cycles.
  - vs_tck is 0 for the first TCK_DIV cycles and 1 for the second.
  - vs_tck is held at 0 in IDLE and RESP.
- Accept: in IDLE, cmd_valid & cmd_ready.
  - Latch cmd_ir into vs_ir_in, which is held until the next accept.
  - Load cmd_dr into shift register sr.
  - Go to UIR on the next cycle; cmd_ready drops that same cycle.
- Strobes are one-hot and asserted for the whole period of their state: vs_uir in UIR, vs_cdr in CDR, vs_sdr in SHIFT, vs_udr in UDR. vs_rti is high in IDLE, RTI and RESP.
- UIR: vs_ir_out is sampled into rsp_ir_out on the clk cycle where vs_tck rises.
- SHIFT: lasts DR_WIDTH periods, counted by bit counter 0..DR_WIDTH-1.
  - vs_tdi = sr[0], stable for the whole period.
  - On the tck-rise cycle: sr <= {vs_tdo, sr[DR_WIDTH-1:1]}.
  - After the last period, sr holds the captured word: the first tdo bit is the LSB.
- Transitions: UDR follows the last SHIFT period; RTI follows UDR; RESP follows RTI.
- RESP: rsp_valid=1 and rsp_dr=sr. Both are held stable until rsp_valid & rsp_ready, then IDLE on the next cycle with cmd_ready=1.
  - A cmd_valid presented while not in IDLE is ignored; the requester holds it.
- Latency: rsp_valid rises exactly (DR_WIDTH+4)·2·TCK_DIV clk cycles after the accept edge. With defaults this is 168.
- TCK_DIV=1: tck toggles every clk. The sampling rule is unchanged: sample on the cycle vs_tck is 1 within the period.
- Back-to-back: the earliest next accept is the cycle after the rsp handshake.

Test Plan:
- Slave model with a 38-bit shift register preloaded 0x15_A5A5_A5A5; cmd_dr=0x2A_5A5A_5A5A, cmd_ir=2'b10 → rsp_dr=0x15_A5A5_A5A5; the slave register ends at 0x2A_5A5A_5A5A; vs_ir_in=2'b10 throughout; rsp_valid at exactly cycle 168.
- vs_ir_out tied to 2'b01 during UIR and 2'b11 elsewhere → rsp_ir_out=2'b01; strobe sequence uir,cdr,sdr×38,udr, each exactly 4 clk long.
- rsp_ready held low for 20 cycles → rsp_valid and rsp_dr are stable and vs_tck stays 0; a cmd_valid pulse during this window is not accepted (cmd_ready=0).
- Reset asserted during SHIFT bit 17 → all outputs at reset values within the same cycle; no rsp_valid afterwards; the next command completes normally.
- TCK_DIV=1, DR_WIDTH=8, loopback tdo=tdi, cmd_dr=0xC3 → rsp_dr=0xC3, latency 24 cycles.
- Two commands back-to-back with rsp_ready=1 → second accept occurs 1 cycle after the first response handshake; both responses are correct.

Source files
------------

// File: rtl/debug_scan_master.sv
// debug_scan_master: host-side initiator for the CPU debug slave's virtual-JTAG
// scan interface. One accepted command walks UIR -> CDR -> SHIFT x DR_WIDTH ->
// UDR -> RTI, one tck period per state, and then presents the captured DR word
// and the slave's ir_out until the response is consumed.

module debug_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vs_tck,
    output logic                vs_tdi,
    input  logic                vs_tdo,
    output logic [IR_WIDTH-1:0] vs_ir_in,
    input  logic [IR_WIDTH-1:0] vs_ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                vs_rti
);

    // One tck period is PERIOD clk cycles; the phase counter walks 0..PERIOD-1.
    localparam int PERIOD = 2 * TCK_DIV;
    localparam int PH_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int BIT_W  = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PERIOD - 1);
    localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(TCK_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        UIR,
        CDR,
        SHIFT,
        UDR,
        RTI,
        RESP
    } state_t;

    state_t              state;
    logic [PH_W-1:0]     phase;
    logic [PH_W-1:0]     phase_inc;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DR_WIDTH-1:0] sr;
    logic [DR_WIDTH-1:0] sr_d;
    logic                period_end;
    logic                tck_rise;
    logic                tck_next;

    // Period bookkeeping and the shift-register update taken on the tck-high
    // cycle; sr_d is also what the next SHIFT period presents on tdi, which
    // matters when TCK_DIV=1 and the shift coincides with the period boundary.
    always_comb begin
        phase_inc  = phase + 1'b1;
        period_end = (phase == PH_LAST);
        tck_rise   = (phase == PH_RISE);
        tck_next   = !period_end && (phase_inc >= PH_RISE);
        sr_d       = sr;
        if (state == SHIFT && tck_rise) begin
            sr_d = {vs_tdo, sr[DR_WIDTH-1:1]};
        end
    end

    // Scan sequencer: state, counters, shift register and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= '0;
            bit_cnt    <= '0;
            sr         <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_dr     <= '0;
            rsp_ir_out <= '0;
            vs_tck     <= 1'b0;
            vs_tdi     <= 1'b0;
            vs_ir_in   <= '0;
            vs_uir     <= 1'b0;
            vs_cdr     <= 1'b0;
            vs_sdr     <= 1'b0;
            vs_udr     <= 1'b0;
            vs_rti     <= 1'b1;
        end else begin
            sr <= sr_d;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state     <= UIR;
                        phase     <= '0;
                        sr        <= cmd_dr;
                        vs_ir_in  <= cmd_ir;
                        cmd_ready <= 1'b0;
                        vs_tck    <= 1'b0;
                        vs_tdi    <= 1'b0;
                        vs_uir    <= 1'b1;
                        vs_rti    <= 1'b0;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    phase  <= period_end ? '0 : phase_inc;
                    vs_tck <= tck_next;
                    if (state == UIR && tck_rise) begin
                        rsp_ir_out <= vs_ir_out;
                    end
                    if (period_end) begin
                        case (state)
                            UIR: begin
                                state  <= CDR;
                                vs_uir <= 1'b0;
                                vs_cdr <= 1'b1;
                            end
                            CDR: begin
                                state   <= SHIFT;
                                bit_cnt <= '0;
                                vs_tdi  <= sr_d[0];
                                vs_cdr  <= 1'b0;
                                vs_sdr  <= 1'b1;
                            end
                            SHIFT: begin
                                if (bit_cnt == BIT_LAST) begin
                                    state  <= UDR;
                                    vs_tdi <= 1'b0;
                                    vs_sdr <= 1'b0;
                                    vs_udr <= 1'b1;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                    vs_tdi  <= sr_d[0];
                                end
                            end
                            UDR: begin
                                state  <= RTI;
                                vs_udr <= 1'b0;
                                vs_rti <= 1'b1;
                            end
                            RTI: begin
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                                rsp_dr    <= sr_d;
                            end
                            default: begin
                                state <= IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_scan_master.sv
// Bench for debug_scan_master: a behavioural virtual-JTAG slave on the default
// instance, a tdo=tdi loopback on a small TCK_DIV=1 instance, and a queue of
// expected responses pushed when a command is issued and popped on rsp_valid.

module tb_debug_scan_master;

    localparam int DRW  = 38;
    localparam int IRW  = 2;
    localparam int DIV  = 2;
    localparam int PER  = 2 * DIV;
    localparam int LAT  = (DRW + 4) * PER;
    localparam int SDRW = 8;

    typedef struct packed {
        logic [DRW-1:0] dr;
        logic [IRW-1:0] ir;
    } rsp_t;

    typedef struct packed {
        logic [SDRW-1:0] dr;
        logic [IRW-1:0]  ir;
    } srsp_t;

    int checks = 0;
    int errors = 0;

    rsp_t  exp_q[$];
    srsp_t sexp_q[$];

    logic           clk;
    logic           reset;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [IRW-1:0] cmd_ir;
    logic [DRW-1:0] cmd_dr;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [DRW-1:0] rsp_dr;
    logic [IRW-1:0] rsp_ir_out;
    logic           vs_tck;
    logic           vs_tdi;
    logic           vs_tdo;
    logic [IRW-1:0] vs_ir_in;
    logic [IRW-1:0] vs_ir_out;
    logic           vs_uir, vs_cdr, vs_sdr, vs_udr, vs_rti;

    logic            s_cmd_valid;
    logic            s_cmd_ready;
    logic [IRW-1:0]  s_cmd_ir;
    logic [SDRW-1:0] s_cmd_dr;
    logic            s_rsp_valid;
    logic            s_rsp_ready;
    logic [SDRW-1:0] s_rsp_dr;
    logic [IRW-1:0]  s_rsp_ir_out;
    logic            s_tck;
    logic            s_tdi;
    logic            s_tdo;
    logic [IRW-1:0]  s_ir_in;
    logic [IRW-1:0]  s_ir_out;
    logic            s_uir, s_cdr, s_sdr, s_udr, s_rti;

    // Behavioural slave state
    logic [DRW-1:0] slave_sr;
    logic [DRW-1:0] slave_init;
    logic [DRW-1:0] slave_expect;
    logic           slave_load = 1'b0;
    logic           slave_cap  = 1'b0;
    logic           slave_pend = 1'b0;

    debug_scan_master #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(DIV)) u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
        .vs_tck(vs_tck), .vs_tdi(vs_tdi), .vs_tdo(vs_tdo),
        .vs_ir_in(vs_ir_in), .vs_ir_out(vs_ir_out),
        .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .vs_rti(vs_rti)
    );

    debug_scan_master #(.DR_WIDTH(SDRW), .IR_WIDTH(IRW), .TCK_DIV(1)) u_small (
        .clk(clk), .reset(reset),
        .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_ir(s_cmd_ir), .cmd_dr(s_cmd_dr),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_dr(s_rsp_dr), .rsp_ir_out(s_rsp_ir_out),
        .vs_tck(s_tck), .vs_tdi(s_tdi), .vs_tdo(s_tdo),
        .vs_ir_in(s_ir_in), .vs_ir_out(s_ir_out),
        .vs_uir(s_uir), .vs_cdr(s_cdr), .vs_sdr(s_sdr), .vs_udr(s_udr), .vs_rti(s_rti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave status is 01 while in UIR and 11 otherwise; the small instance loops tdo back to tdi
    assign vs_tdo    = slave_sr[0];
    assign vs_ir_out = vs_uir ? 2'b01 : 2'b11;
    assign s_tdo     = s_tdi;
    assign s_ir_out  = 2'b10;

    // Slave captures tdi on tck rise and shifts on tck fall, so tdo is stable for a whole period
    always @(posedge vs_tck or negedge vs_tck or posedge slave_load) begin
        if (slave_load) begin
            slave_sr   = slave_init;
            slave_pend = 1'b0;
        end else if (vs_tck) begin
            if (vs_sdr) begin
                slave_cap  = vs_tdi;
                slave_pend = 1'b1;
            end
        end else if (slave_pend) begin
            slave_sr   = {slave_cap, slave_sr[DRW-1:1]};
            slave_pend = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic load_slave(input logic [DRW-1:0] value);
        slave_init   = value;
        slave_expect = value;
        slave_load   = 1'b1;
        #1;
        slave_load   = 1'b0;
    endtask

    task automatic accept_main(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr);
        cmd_ir    = ir;
        cmd_dr    = dr;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] got;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0; rsp_ready = 1'b0;
        s_cmd_valid = 1'b0; s_cmd_ir = '0; s_cmd_dr = '0; s_rsp_ready = 1'b0;
        load_slave('0);
        repeat (3) @(posedge clk);
        #1;
        got = {cmd_ready, rsp_valid, vs_tck, vs_tdi, vs_uir, vs_cdr, vs_sdr, vs_udr, vs_rti, vs_ir_in};
        checks++;
        if (got !== 11'b1_0_0_0_0_0_0_0_1_00) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=%b", got, 11'b10000000100);
        end
        checks++;
        if (rsp_dr !== '0) begin errors++; $display("FAIL reset_rsp_dr got=%h exp=0", rsp_dr); end
        checks++;
        if (rsp_ir_out !== '0) begin errors++; $display("FAIL reset_rsp_ir got=%b exp=00", rsp_ir_out); end
        checks++;
        if (s_cmd_ready !== 1'b1 || s_rti !== 1'b1 || s_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_small got ready=%b rti=%b valid=%b exp 1 1 0", s_cmd_ready, s_rti, s_rsp_valid);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [DRW-1:0] dr;
        rsp_t e;
        int k, p, bad_seq;
        logic [4:0] exp_s;
        dr = 38'h2A_5A5A_5A5A;
        load_slave(38'h15_A5A5_A5A5);
        rsp_ready = 1'b1;
        e.dr = slave_expect; e.ir = 2'b01;
        exp_q.push_back(e);
        accept_main(2'b10, dr);
        k = 0; bad_seq = 0;
        while (rsp_valid !== 1'b1 && k < 400) begin
            p = k / PER;
            if (p == 0)             exp_s = 5'b10000;
            else if (p == 1)        exp_s = 5'b01000;
            else if (p <= DRW + 1)  exp_s = 5'b00100;
            else if (p == DRW + 2)  exp_s = 5'b00010;
            else                    exp_s = 5'b00001;
            if ({vs_uir, vs_cdr, vs_sdr, vs_udr, vs_rti} !== exp_s ||
                vs_tck !== ((k % PER) >= DIV) || vs_ir_in !== 2'b10 || cmd_ready !== 1'b0)
                bad_seq++;
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (k != LAT) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", k, LAT); end
        checks++;
        if (bad_seq != 0) begin errors++; $display("FAIL basic_strobe_seq bad_cycles=%0d exp=0", bad_seq); end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL basic_queue empty on response");
        end else begin
            e = exp_q.pop_front();
            if (rsp_dr !== e.dr || rsp_ir_out !== e.ir) begin
                errors++; $display("FAIL basic_rsp got dr=%h ir=%b exp dr=%h ir=%b", rsp_dr, rsp_ir_out, e.dr, e.ir);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL basic_return_idle got ready=%b valid=%b exp 1 0", cmd_ready, rsp_valid);
        end
        checks++;
        if (slave_sr !== dr) begin errors++; $display("FAIL basic_slave_reg got=%h exp=%h", slave_sr, dr); end
        slave_expect = dr;
    endtask

    task automatic test_resp_hold();
        logic [DRW-1:0] dr;
        rsp_t e;
        int k, held_bad;
        dr = DRW'({$urandom(), $urandom()});
        rsp_ready = 1'b0;
        e.dr = slave_expect; e.ir = 2'b01;
        exp_q.push_back(e);
        accept_main(2'b11, dr);
        k = 0;
        while (rsp_valid !== 1'b1 && k < 400) begin
            @(posedge clk); #1; k++;
        end
        checks++;
        if (k != LAT) begin errors++; $display("FAIL hold_latency got=%0d exp=%0d", k, LAT); end
        e = exp_q.pop_front();
        checks++;
        if (rsp_dr !== e.dr || rsp_ir_out !== e.ir) begin
            errors++; $display("FAIL hold_rsp got dr=%h ir=%b exp dr=%h ir=%b", rsp_dr, rsp_ir_out, e.dr, e.ir);
        end
        held_bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin cmd_ir = 2'b01; cmd_dr = ~dr; cmd_valid = 1'b1; end
            if (i == 6) cmd_valid = 1'b0;
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b1 || rsp_dr !== e.dr || vs_tck !== 1'b0 ||
                cmd_ready !== 1'b0 || vs_uir !== 1'b0)
                held_bad++;
        end
        checks++;
        if (held_bad != 0) begin errors++; $display("FAIL hold_stable bad_cycles=%0d exp=0", held_bad); end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || vs_ir_in !== 2'b11) begin
            errors++; $display("FAIL hold_release got ready=%b valid=%b ir_in=%b exp 1 0 11", cmd_ready, rsp_valid, vs_ir_in);
        end
        slave_expect = dr;
    endtask

    task automatic test_reset_mid();
        logic [DRW-1:0] dr;
        logic [10:0] got;
        rsp_t e;
        int k, seen;
        load_slave(38'h0F_0F0F_1234);
        rsp_ready = 1'b1;
        dr = DRW'({$urandom(), $urandom()});
        accept_main(2'b01, dr);
        repeat (PER * (2 + 17)) @(posedge clk);
        #2;
        checks++;
        if (vs_sdr !== 1'b1) begin errors++; $display("FAIL midrst_in_shift got sdr=%b exp=1", vs_sdr); end
        reset = 1'b1;
        #1;
        got = {cmd_ready, rsp_valid, vs_tck, vs_tdi, vs_uir, vs_cdr, vs_sdr, vs_udr, vs_rti, vs_ir_in};
        checks++;
        if (got !== 11'b1_0_0_0_0_0_0_0_1_00) begin
            errors++; $display("FAIL midrst_ctrl got=%b exp=%b", got, 11'b10000000100);
        end
        checks++;
        if (rsp_dr !== '0 || rsp_ir_out !== '0) begin
            errors++; $display("FAIL midrst_rsp got dr=%h ir=%b exp 0 00", rsp_dr, rsp_ir_out);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 250; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1 || vs_uir === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midrst_no_rsp got=%0d active cycles exp=0", seen); end
        load_slave(38'h2B_DEAD_BEEF);
        e.dr = slave_expect; e.ir = 2'b01;
        exp_q.push_back(e);
        dr = 38'h01_8000_0001;
        accept_main(2'b10, dr);
        k = 0;
        while (rsp_valid !== 1'b1 && k < 400) begin
            @(posedge clk); #1; k++;
        end
        checks++;
        if (k != LAT) begin errors++; $display("FAIL midrst_next_latency got=%0d exp=%0d", k, LAT); end
        e = exp_q.pop_front();
        checks++;
        if (rsp_dr !== e.dr || rsp_ir_out !== e.ir) begin
            errors++; $display("FAIL midrst_next_rsp got dr=%h ir=%b exp dr=%h ir=%b", rsp_dr, rsp_ir_out, e.dr, e.ir);
        end
        @(posedge clk);
        #1;
        slave_expect = dr;
    endtask

    task automatic test_tckdiv1();
        logic [SDRW-1:0] vals [2];
        srsp_t e;
        int k;
        vals[0] = 8'hC3;
        vals[1] = 8'h81;
        s_rsp_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            e.dr = vals[n]; e.ir = 2'b10;
            sexp_q.push_back(e);
            s_cmd_ir = 2'b01; s_cmd_dr = vals[n]; s_cmd_valid = 1'b1;
            @(posedge clk);
            #1;
            s_cmd_valid = 1'b0;
            k = 0;
            while (s_rsp_valid !== 1'b1 && k < 100) begin
                @(posedge clk); #1; k++;
            end
            checks++;
            if (k != (SDRW + 4) * 2) begin errors++; $display("FAIL div1_latency got=%0d exp=%0d", k, (SDRW + 4) * 2); end
            e = sexp_q.pop_front();
            checks++;
            if (s_rsp_dr !== e.dr || s_rsp_ir_out !== e.ir) begin
                errors++; $display("FAIL div1_rsp got dr=%h ir=%b exp dr=%h ir=%b", s_rsp_dr, s_rsp_ir_out, e.dr, e.ir);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [DRW-1:0] dra, drb;
        rsp_t e;
        int k;
        dra = DRW'({$urandom(), $urandom()});
        drb = DRW'({$urandom(), $urandom()});
        rsp_ready = 1'b1;
        e.dr = slave_expect; e.ir = 2'b01; exp_q.push_back(e);
        e.dr = dra;          e.ir = 2'b01; exp_q.push_back(e);
        accept_main(2'b10, dra);
        k = 0;
        while (rsp_valid !== 1'b1 && k < 400) begin
            @(posedge clk); #1; k++;
        end
        e = exp_q.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_dr !== e.dr || rsp_ir_out !== e.ir) begin
            errors++; $display("FAIL b2b_first_rsp got v=%b dr=%h ir=%b exp v=1 dr=%h ir=%b", rsp_valid, rsp_dr, rsp_ir_out, e.dr, e.ir);
        end
        cmd_ir = 2'b01; cmd_dr = drb; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || vs_uir !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got ready=%b uir=%b exp 1 0", cmd_ready, vs_uir);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0 || vs_uir !== 1'b1 || vs_ir_in !== 2'b01) begin
            errors++; $display("FAIL b2b_accept got ready=%b uir=%b ir_in=%b exp 0 1 01", cmd_ready, vs_uir, vs_ir_in);
        end
        k = 0;
        while (rsp_valid !== 1'b1 && k < 400) begin
            @(posedge clk); #1; k++;
        end
        checks++;
        if (k != LAT) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=%0d", k, LAT); end
        e = exp_q.pop_front();
        checks++;
        if (rsp_dr !== e.dr || rsp_ir_out !== e.ir) begin
            errors++; $display("FAIL b2b_second_rsp got dr=%h ir=%b exp dr=%h ir=%b", rsp_dr, rsp_ir_out, e.dr, e.ir);
        end
        @(posedge clk);
        #1;
        checks++;
        if (slave_sr !== drb) begin errors++; $display("FAIL b2b_slave_reg got=%h exp=%h", slave_sr, drb); end
        slave_expect = drb;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_resp_hold();
        test_reset_mid();
        test_tckdiv1();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0 || sexp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", exp_q.size(), sexp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
